// File: rtl/screen_driver.sv
// -----------------------------------------------------------------------------
// screen_driver
//
// Converts a signed, fixed-point BCD number into per-digit 7-segment patterns
// and time-multiplexes them onto a shared cathode bus with one anode per digit.
//
// Configuration macro:
//   SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
//     defined   : leading zeros are blanked and a minus digit is placed just
//                 left of the significant part (dropped if there is no room).
//     undefined : every digit shows its numeral; a negative number lights the
//                 decimal point of the leftmost digit instead.
//
// Ports:
//   clk_i                    clock, all state on the rising edge
//   rst_ni                   synchronous active-low reset
//   num_i                    number to show (error, sign, point, BCD digits)
//   override_shift_amount_i  1 = take point position from new_shift_amount_i
//   new_shift_amount_i       replacement point position (don't-care when
//                            override is 0)
//   display_segments_o       registered per-digit patterns, active-high,
//                            bit7 = DP, bits 6:0 = g..a
//   segments_cathode_o       active-low pattern of the currently scanned digit
//   segments_anode_o         one-hot-low enable of the currently scanned digit
// -----------------------------------------------------------------------------
package calc_pkg;
  parameter int NumDigits = 8;

  typedef struct packed {
    logic                      error;
    logic                      sign;
    logic [2:0]                point;
    logic [NumDigits-1:0][3:0] digits;
  } num_t;
endpackage

module screen_driver #(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  calc_pkg::num_t            num_i,
  input  logic                      override_shift_amount_i,
  input  logic [2:0]                new_shift_amount_i,
  output logic [NumDigits-1:0][7:0] display_segments_o,
  output logic [7:0]                segments_cathode_o,
  output logic [NumDigits-1:0]      segments_anode_o
);

  localparam int ScanW = (NumDigits > 1) ? $clog2(NumDigits) : 1;

  localparam logic [7:0] SegMinus = 8'h40;

  function automatic logic [6:0] encode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;  // non-BCD codes render as "E"
    endcase
    return s;
  endfunction

  logic [NumDigits-1:0][7:0] segs_p0;
  logic [NumDigits-1:0][7:0] segs_p1;
  logic [ScanW-1:0]          scan_p1;
  logic                      vld_p1;
  int                        point;
`ifdef SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
  int                        top_nz;
  int                        extent;
`endif

  // ---- stage p0: combinational formatting of the incoming number ----
  always_comb begin
    segs_p0 = '0;
    point   = int'(override_shift_amount_i ? new_shift_amount_i : num_i.point);
`ifdef SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
    top_nz  = 0;
    for (int i = 0; i < NumDigits; i++) begin
      if (num_i.digits[i] != 4'd0) top_nz = i;
    end
    // The point forces zeros up to its digit to stay visible ("0.05").
    extent  = (point > top_nz) ? point : top_nz;
`endif
    for (int i = 0; i < NumDigits; i++) begin
      segs_p0[i] = {1'b0, encode_digit(num_i.digits[i])};
      if (point != 0 && i == point) segs_p0[i][7] = 1'b1;
`ifdef SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
      if (i > extent) segs_p0[i] = '0;
      // When extent is the leftmost digit there is no slot, so no sign.
      if (num_i.sign && i == extent + 1) segs_p0[i] = SegMinus;
`else
      if (num_i.sign && i == NumDigits - 1) segs_p0[i][7] = 1'b1;
`endif
      if (num_i.error) segs_p0[i] = SegMinus;
    end
  end

  // ---- stage p1: registered patterns and scan position ----
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      segs_p1 <= '0;
      scan_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      segs_p1 <= segs_p0;
      vld_p1  <= 1'b1;
      // Hold at digit 0 on the first edge out of reset so the new frame
      // starts there rather than at digit 1.
      if (vld_p1) begin
        if (scan_p1 == ScanW'(NumDigits - 1)) scan_p1 <= '0;
        else                                  scan_p1 <= scan_p1 + 1'b1;
      end
    end
  end

  always_comb begin
    segments_anode_o          = '1;
    segments_cathode_o        = '1;
    if (vld_p1) begin
      segments_anode_o[scan_p1] = 1'b0;
      segments_cathode_o        = ~segs_p1[scan_p1];
    end
  end

  assign display_segments_o = segs_p1;

endmodule

// File: tb/tb_screen_driver.sv
module tb_screen_driver;

  logic                clk = 1'b0;
  logic                rst_n;
  calc_pkg::num_t      num;
  logic                ovr;
  logic [2:0]          new_shift;
  logic [7:0][7:0]     disp;
  logic [7:0]          cathode;
  logic [7:0]          anode;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_seg [8];

  always #5 clk = ~clk;

  screen_driver dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .num_i                   (num),
    .override_shift_amount_i (ovr),
    .new_shift_amount_i      (new_shift),
    .display_segments_o      (disp),
    .segments_cathode_o      (cathode),
    .segments_anode_o        (anode)
  );

  task automatic set_num(input logic err, input logic sgn, input logic [2:0] pt,
                         input logic [31:0] bcd);
    num.error  = err;
    num.sign   = sgn;
    num.point  = pt;
    num.digits = bcd;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    ovr       = 1'b0;
    new_shift = 'x;
    set_num(1'b0, 1'b0, 3'd0, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (disp !== '0) begin
      n_fail++; $display("FAIL reset_display: got %h expected 0", disp);
    end
    n_checks++;
    if (anode !== 8'hFF) begin
      n_fail++; $display("FAIL reset_anode: got %h expected ff", anode);
    end
    n_checks++;
    if (cathode !== 8'hFF) begin
      n_fail++; $display("FAIL reset_cathode: got %h expected ff", cathode);
    end
  endtask

  task automatic test_scan_zero;
`ifdef SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
    exp_seg = '{8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    exp_seg = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (anode !== ~(8'h01 << (k % 8))) begin
        n_fail++;
        $display("FAIL scan_anode step %0d: got %h expected %h", k, anode, ~(8'h01 << (k % 8)));
      end
      n_checks++;
      if (cathode !== ~exp_seg[k % 8]) begin
        n_fail++;
        $display("FAIL scan_cathode step %0d: got %h expected %h", k, cathode, ~exp_seg[k % 8]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (disp[i] !== exp_seg[i]) begin
        n_fail++; $display("FAIL zero_digit%0d: got %h expected %h", i, disp[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_negative_point;
`ifdef SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
    exp_seg = '{8'h66, 8'h4F, 8'hDB, 8'h06, 8'h40, 8'h00, 8'h00, 8'h00};
`else
    exp_seg = '{8'h66, 8'h4F, 8'hDB, 8'h06, 8'h3F, 8'h3F, 8'h3F, 8'hBF};
`endif
    @(negedge clk);
    set_num(1'b0, 1'b1, 3'd2, 32'h0000_1234);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (disp[i] !== exp_seg[i]) begin
        n_fail++; $display("FAIL neg1234_digit%0d: got %h expected %h", i, disp[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_point_padding;
`ifdef SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
    exp_seg = '{8'h6D, 8'h3F, 8'h3F, 8'hBF, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    exp_seg = '{8'h6D, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
`endif
    @(negedge clk);
    set_num(1'b0, 1'b0, 3'd3, 32'h0000_0005);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (disp[i] !== exp_seg[i]) begin
        n_fail++; $display("FAIL pad5_digit%0d: got %h expected %h", i, disp[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_sign_dropped;
`ifdef SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN
    exp_seg = '{8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06};
`else
    exp_seg = '{8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h86};
`endif
    @(negedge clk);
    set_num(1'b0, 1'b1, 3'd0, 32'h1234_5678);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (disp[i] !== exp_seg[i]) begin
        n_fail++; $display("FAIL full_digit%0d: got %h expected %h", i, disp[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_override;
    @(negedge clk);
    ovr       = 1'b1;
    new_shift = 3'd4;
    #1;
    n_checks++;
    if (disp[4] !== 8'h66) begin
      n_fail++; $display("FAIL ovr_before_edge: got %h expected 66", disp[4]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (disp[4] !== 8'hE6) begin
      n_fail++; $display("FAIL ovr_dp_digit4: got %h expected e6", disp[4]);
    end
    n_checks++;
    if (disp[0] !== 8'h7F) begin
      n_fail++; $display("FAIL ovr_digit0: got %h expected 7f", disp[0]);
    end
    @(negedge clk);
    ovr       = 1'b0;
    new_shift = 'x;
    @(posedge clk);
    #1;
    n_checks++;
    if (disp[4] !== 8'h66) begin
      n_fail++; $display("FAIL ovr_restore_digit4: got %h expected 66", disp[4]);
    end
    n_checks++;
    if ($isunknown({disp, anode, cathode})) begin
      n_fail++; $display("FAIL no_x_outputs: got %h %h %h expected no X", disp, anode, cathode);
    end
  endtask

  task automatic test_error_and_midreset;
    @(negedge clk);
    set_num(1'b1, 1'b1, 3'd5, 32'h9876_5432);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (disp[i] !== 8'h40) begin
        n_fail++; $display("FAIL error_digit%0d: got %h expected 40", i, disp[i]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (anode !== 8'hFF || cathode !== 8'hFF || disp !== '0) begin
      n_fail++;
      $display("FAIL midreset_dark: got an=%h ca=%h disp=%h expected ff ff 0", anode, cathode, disp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (anode !== 8'hFE) begin
      n_fail++; $display("FAIL restart_anode0: got %h expected fe", anode);
    end
    n_checks++;
    if (cathode !== 8'hBF) begin
      n_fail++; $display("FAIL restart_cathode0: got %h expected bf", cathode);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (anode !== 8'hFD) begin
      n_fail++; $display("FAIL restart_anode1: got %h expected fd", anode);
    end
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_negative_point();
    test_point_padding();
    test_sign_dropped();
    test_override();
    test_error_and_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_driver.md
SCREEN_DRIVER -- requirements
Module: screen_driver

Interface
REQ-001 NumDigits: default 8 (from calc_pkg); number of 7-segment digits; digit 0 is rightmost.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 num_i  input  calc_pkg::num_t  number to show: error flag, sign, point[2:0] (fractional-digit count), digits[NumDigits-1:0][3:0] BCD.
REQ-005 override_shift_amount_i  input  1  1 = use new_shift_amount_i instead of num_i.point.
REQ-006 new_shift_amount_i  input  3  replacement point position; ignored (may be X) when override is 0.
REQ-007 display_segments_o  output  NumDigits x 8  registered per-digit patterns, active-high; bit7 = DP, bits 6:0 = g..a.
REQ-008 segments_cathode_o  output  8  scanned pattern of the current digit, active-low (~display_segments_o[scan]).
REQ-009 segments_anode_o  output  NumDigits  one-hot-low digit enable for the current scan digit.

Function
REQ-010 Effective point P SHALL be new_shift_amount_i when override_shift_amount_i=1, else num_i.point.
REQ-011 Digit encodings SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; BCD 10-15 -> 79 ("E"); minus -> 40; blank -> 00 (hex, bits 6:0).
REQ-012 DP SHALL be lit on digit P when P != 0; no DP when P = 0.
REQ-013 Significant extent SHALL be max(index of highest nonzero digit, P); digits above it are leading zeros.
REQ-014 Leading-zero handling SHALL follow REQ-026.
REQ-015 Negative sign SHALL occupy the digit immediately left of the significant extent; if the extent is digit NumDigits-1, the sign SHALL be dropped.
REQ-016 num_i.error = 1 SHALL force every digit to minus (40), no DP, regardless of other fields.
REQ-017 display_segments_o SHALL update exactly one clock after num_i or override inputs change (one register stage).
REQ-018 A scan counter SHALL advance 0,1,...,NumDigits-1 one step per clock and wrap to 0.
REQ-019 segments_anode_o SHALL drive bit [scan] low and all others high; segments_cathode_o SHALL equal ~display_segments_o[scan] in the same cycle.
REQ-020 Every digit SHALL therefore be presented once per NumDigits clocks; an input change is fully visible on the scanned outputs within NumDigits+1 clocks.
REQ-021 The override SHALL be combinational per cycle: deasserting it restores num_i.point on the next registered update; no state is held.

Reset
REQ-022 While rst_ni=0 at a rising edge: display_segments_o = all 0, scan counter = 0.
REQ-023 During reset segments_anode_o SHALL be all 1 and segments_cathode_o all 1 (display dark).
REQ-024 Scanning SHALL resume at digit 0 on the first edge after rst_ni rises; reset mid-scan SHALL abandon the current frame.
REQ-025 No output SHALL be X after reset, including when new_shift_amount_i is X with override=0.

Configuration
REQ-026 Macro SCREEN_DRIVER_BLANK_LEADING_ZEROS_EN: defined -> leading zeros show blank (00) and sign per REQ-015; undefined -> all digits show their numeral, and a negative number is flagged by lighting DP of digit NumDigits-1 instead of a minus digit.

Verification
REQ-027 Reset, then num=+00000000, P=0 -> (macro on) digit0=3F, digits1-7=00; anodes step FE,FD,...,7F then wrap.
REQ-028 num=-00001234, P=2 -> digits 0..3 = 66,4F,5B+DP(DB),06; digit4=40; digits5-7=00.
REQ-029 num=+00000005, P=3 -> digit0=6D, digit1=3F, digit2=3F, digit3=BF, digits4-7=00.
REQ-030 num=-12345678, P=0 -> all eight numerals shown, sign dropped; macro off -> digit7 = 86.
REQ-031 Same num, override=1, new_shift_amount=4 -> DP moves to digit4 one clock later; override=0 restores.
REQ-032 error=1 -> all digits 40; assert rst_ni=0 mid-scan -> next edge all outputs dark, scan restarts at digit 0.
